// File: rtl/ssd_rotation_monitor_if.sv
// Segment-bus and status bundle for the rotating "dE10" display monitor.
// master = display side / observer, slave = the monitor itself.
interface ssd_rotation_monitor_if;
  logic [6:0]  HEX3;
  logic [6:0]  HEX2;
  logic [6:0]  HEX1;
  logic [6:0]  HEX0;
  logic [1:0]  Phase;
  logic        PhaseValid;
  logic        Locked;
  logic        StepTick;
  logic        SeqErr;
  logic [7:0]  ErrCount;
  logic [25:0] Period;

  modport master (
    output HEX3, HEX2, HEX1, HEX0,
    input  Phase, PhaseValid, Locked,
    input  StepTick, SeqErr, ErrCount, Period
  );

  modport slave (
    input  HEX3, HEX2, HEX1, HEX0,
    output Phase, PhaseValid, Locked,
    output StepTick, SeqErr, ErrCount, Period
  );
endinterface

// File: rtl/ssd_rotation_monitor.sv
// Recovers and checks the phase of the rotating "dE10" seven-segment message.
// Define SSD_MON_PERIOD_EN to build the step-period measurement.
module ssd_rotation_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_STEPS    = 2
) (
  input logic                   CLOCK_50,
  input logic                   Clr,
  ssd_rotation_monitor_if.slave bus
);

  localparam logic [6:0] CH_D = 7'h21;
  localparam logic [6:0] CH_E = 7'h06;
  localparam logic [6:0] CH_1 = 7'h79;
  localparam logic [6:0] CH_0 = 7'h40;

  localparam logic [27:0] W0 = {CH_D, CH_E, CH_1, CH_0};
  localparam logic [27:0] W1 = {CH_E, CH_1, CH_0, CH_D};
  localparam logic [27:0] W2 = {CH_1, CH_0, CH_D, CH_E};
  localparam logic [27:0] W3 = {CH_0, CH_D, CH_E, CH_1};

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_STEPS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic [27:0] sync1, sync2, prev, acc_word;
  logic [7:0]  stab_cnt, stab_nxt;
  logic        accept;

  logic [1:0]  state;
  logic [1:0]  phase, phase_nxt;
  logic        phase_valid;
  logic        step_tick, seq_err;
  logic [7:0]  err_cnt, err_inc;
  logic [3:0]  steps, steps_inc;

  logic        dec_valid;
  logic [1:0]  dec_phase;
  logic        step_ok;

  // Remembering the last accepted word keeps short glitches that return
  // to it from being re-accepted as a fresh (and bogus) step.
  always_comb begin
    stab_nxt = stab_cnt;
    if (sync2 != prev)
      stab_nxt = 8'd0;
    else if (stab_cnt != STAB_MAX)
      stab_nxt = stab_cnt + 8'd1;
    accept = (stab_nxt == STAB_MAX) && (sync2 != acc_word);
  end

  always_ff @(posedge CLOCK_50 or posedge Clr) begin
    if (Clr) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      acc_word <= '0;
      stab_cnt <= '0;
    end else begin
      sync1    <= {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
      sync2    <= sync1;
      prev     <= sync2;
      stab_cnt <= stab_nxt;
      if (accept)
        acc_word <= sync2;
    end
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_phase = 2'd0;
    unique case (1'b1)
      (sync2 == W0): dec_phase = 2'd0;
      (sync2 == W1): dec_phase = 2'd1;
      (sync2 == W2): dec_phase = 2'd2;
      (sync2 == W3): dec_phase = 2'd3;
      default:       dec_valid = 1'b0;
    endcase
  end

  assign phase_nxt = phase + 2'd1;
  assign err_inc   = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
  assign steps_inc = (steps == 4'hf) ? steps : steps + 4'd1;
  assign step_ok   = dec_valid && (state != IDLE) && (dec_phase == phase_nxt);

  always_ff @(posedge CLOCK_50 or posedge Clr) begin
    if (Clr) begin
      state       <= IDLE;
      phase       <= '0;
      phase_valid <= 1'b0;
      step_tick   <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
      steps       <= '0;
    end else begin
      step_tick <= 1'b0;
      seq_err   <= 1'b0;
      if (accept) begin
        if (!dec_valid) begin
          phase_valid <= 1'b0;
          state       <= IDLE;
          if (state != IDLE) begin
            seq_err <= 1'b1;
            err_cnt <= err_inc;
          end
        end else if (state == IDLE) begin
          phase       <= dec_phase;
          phase_valid <= 1'b1;
          steps       <= '0;
          state       <= ACQUIRE;
        end else if (step_ok) begin
          phase     <= dec_phase;
          step_tick <= 1'b1;
          steps     <= steps_inc;
          if (state == ACQUIRE && steps_inc >= LOCK_N)
            state <= LOCKED;
        end else begin
          seq_err <= 1'b1;
          err_cnt <= err_inc;
          phase   <= dec_phase;
          steps   <= '0;
          state   <= ACQUIRE;
        end
      end
    end
  end

`ifdef SSD_MON_PERIOD_EN
  localparam logic [25:0] PMAX = '1;

  logic [25:0] pcnt, period;

  // The +1 accounts for the accept edge itself, so steps N apart read N.
  always_ff @(posedge CLOCK_50 or posedge Clr) begin
    if (Clr) begin
      pcnt   <= '0;
      period <= '0;
    end else begin
      if (accept)
        pcnt <= '0;
      else if (pcnt != PMAX)
        pcnt <= pcnt + 26'd1;
      if (accept && step_ok)
        period <= (pcnt == PMAX) ? PMAX : pcnt + 26'd1;
    end
  end

  assign bus.Period = period;
`else
  assign bus.Period = 26'd0;
`endif

  assign bus.Phase      = phase;
  assign bus.PhaseValid = phase_valid;
  assign bus.Locked     = (state == LOCKED);
  assign bus.StepTick   = step_tick;
  assign bus.SeqErr     = seq_err;
  assign bus.ErrCount   = err_cnt;

endmodule

// File: tb/tb_ssd_rotation_monitor.sv
// Directed bench for ssd_rotation_monitor.
// Period expectations follow SSD_MON_PERIOD_EN.
module tb_ssd_rotation_monitor;

  localparam int S = 4;
  localparam int L = 2;

  localparam logic [6:0] D   = 7'h21;
  localparam logic [6:0] E   = 7'h06;
  localparam logic [6:0] ONE = 7'h79;
  localparam logic [6:0] Z   = 7'h40;

`ifdef SSD_MON_PERIOD_EN
  localparam int PER100 = 100;
`else
  localparam int PER100 = 0;
`endif

  logic clk = 1'b0;
  logic clr;

  always #10 clk = ~clk;

  ssd_rotation_monitor_if bus();

  ssd_rotation_monitor #(
    .STABLE_CYCLES(S),
    .LOCK_STEPS   (L)
  ) dut (
    .CLOCK_50(clk),
    .Clr     (clr),
    .bus     (bus)
  );

  int checks     = 0;
  int errors     = 0;
  int ticks_seen = 0;
  int errs_seen  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] pat(input int p);
    case (p)
      0:       return {D, E, ONE, Z};
      1:       return {E, ONE, Z, D};
      2:       return {ONE, Z, D, E};
      3:       return {Z, D, E, ONE};
      default: return '1;
    endcase
  endfunction

  task automatic set_word(input logic [27:0] w);
    {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} = w;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.StepTick) ticks_seen++;
      if (bus.SeqErr)   errs_seen++;
    end
  endtask

  task automatic clr_cnt();
    ticks_seen = 0;
    errs_seen  = 0;
  endtask

  initial begin
    clr = 1'b1;
    set_word('1);
    hold(3);
    chk("rst_phase",  32'(bus.Phase),      0);
    chk("rst_pv",     32'(bus.PhaseValid), 0);
    chk("rst_lock",   32'(bus.Locked),     0);
    chk("rst_errcnt", 32'(bus.ErrCount),   0);
    chk("rst_period", 32'(bus.Period),     0);
    clr = 1'b0;
    hold(10);
    chk("blank_idle_err", 32'(bus.ErrCount), 0);

    // acquire: output must not move before edge k+1+S
    set_word(pat(0));
    hold(S + 1);
    chk("acq_early_pv", 32'(bus.PhaseValid), 0);
    hold(1);
    chk("acq_pv",    32'(bus.PhaseValid), 1);
    chk("acq_phase", 32'(bus.Phase),      0);
    chk("acq_lock",  32'(bus.Locked),     0);
    hold(100 - S - 2);
    clr_cnt();

    set_word(pat(1)); hold(100);
    chk("s1_phase", 32'(bus.Phase),  1);
    chk("s1_lock",  32'(bus.Locked), 0);
    set_word(pat(2)); hold(100);
    chk("s2_lock",  32'(bus.Locked), 1);
    set_word(pat(3)); hold(100);
    set_word(pat(0)); hold(100);
    chk("rot_ticks",  ticks_seen,          4);
    chk("rot_errs",   errs_seen,           0);
    chk("rot_phase",  32'(bus.Phase),      0);
    chk("rot_period", 32'(bus.Period),     PER100);
    chk("rot_errcnt", 32'(bus.ErrCount),   0);

    // skip error while locked at phase 1
    set_word(pat(1)); hold(100);
    clr_cnt();
    set_word(pat(3)); hold(100);
    chk("skip_errs",   errs_seen,         1);
    chk("skip_errcnt", 32'(bus.ErrCount), 1);
    chk("skip_phase",  32'(bus.Phase),    3);
    chk("skip_lock",   32'(bus.Locked),   0);
    chk("skip_period", 32'(bus.Period),   PER100);
    set_word(pat(0)); hold(100);
    chk("re1_lock", 32'(bus.Locked), 0);
    set_word(pat(1)); hold(100);
    chk("re2_lock",  32'(bus.Locked), 1);
    chk("re_ticks",  ticks_seen,      2);

    // blank while locked
    clr_cnt();
    set_word('1); hold(10);
    chk("blank_pv",     32'(bus.PhaseValid), 0);
    chk("blank_lock",   32'(bus.Locked),     0);
    chk("blank_errcnt", 32'(bus.ErrCount),   2);
    chk("blank_phase",  32'(bus.Phase),      1);
    chk("blank_errs",   errs_seen,           1);

    // short glitch must be invisible
    clr_cnt();
    set_word(pat(0)); hold(2);
    set_word('1);     hold(20);
    chk("gl_pv",     32'(bus.PhaseValid), 0);
    chk("gl_phase",  32'(bus.Phase),      1);
    chk("gl_errcnt", 32'(bus.ErrCount),   2);
    chk("gl_pulses", ticks_seen + errs_seen, 0);

    // error counter saturation
    set_word(pat(0)); hold(8);
    clr_cnt();
    for (int i = 0; i < 300; i++) begin
      set_word(pat((i % 2 == 0) ? 2 : 0));
      hold(8);
    end
    chk("sat_errcnt", 32'(bus.ErrCount), 255);
    chk("sat_errs",   errs_seen,         300);

    // async clear mid-hold
    set_word(pat(1)); hold(3);
    #2 clr = 1'b1;
    #1;
    chk("clr_phase",  32'(bus.Phase),      0);
    chk("clr_pv",     32'(bus.PhaseValid), 0);
    chk("clr_errcnt", 32'(bus.ErrCount),   0);
    chk("clr_period", 32'(bus.Period),     0);
    chk("clr_pulse",  32'(bus.StepTick | bus.SeqErr | bus.Locked), 0);
    hold(2);
    clr = 1'b0;
    hold(20);
    chk("reacq_pv",     32'(bus.PhaseValid), 1);
    chk("reacq_phase",  32'(bus.Phase),      1);
    chk("reacq_errcnt", 32'(bus.ErrCount),   0);
    chk("reacq_lock",   32'(bus.Locked),     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
